i2c_target_rx: RTL and testbench

Oversampling I2C target-side receiver: the listening end of the bus whose SCL is generated by the team's clock divider. Runs on the fast reference clock and filters SCL/SDA. Detects START, repeated START and STOP. Decodes the address byte against a run-time own address, then ACKs and delivers write-data bytes to the address-translation logic. Read transfers (R/W=1) are not served and are always NACKed.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_filter.sv | 74 +++++++
 rtl/i2c_target_rx.sv | 199 +++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared state encoding and bus constants for the I2C target receiver.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } i2c_state_e;

  localparam logic        I2C_RW_WRITE  = 1'b0;
  localparam logic        I2C_ACK       = 1'b0;
  localparam int unsigned I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer, optional glitch filter and edge detect for one I2C line.
// The saturating glitch filter is built only when I2C_RX_GLITCH_FILTER_EN is defined.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic ref_clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic prev_d;
  logic filt_c;

  // Synchronizer is left unreset so the true pad level is known when reset ends.
  always_ff @(posedge ref_clk) begin
    sync1_q <= line_in;
    sync2_q <= sync1_q;
  end

`ifdef I2C_RX_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = sync2_q;
      else                                 cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Reload from the synchronized level so leaving reset never fabricates an edge.
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      filt_q <= sync2_q;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_c = filt_q;
`else
  assign filt_c = sync2_q;

  // FILTER_LEN has no effect when the filter is bypassed.
  if (FILTER_LEN > 7) begin : g_filter_len_unused
  end
`endif

  assign prev_d = filt_c;

  always_ff @(posedge ref_clk) begin
    if (!reset) prev_q <= sync2_q;
    else        prev_q <= prev_d;
  end

  assign level  = filt_c;
  assign rise_c = filt_c & ~prev_q;
  assign fall_c = ~filt_c & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Oversampling I2C target receiver: START/STOP detect, address match, write-data capture.
// Glitch filtering on SCL/SDA is enabled by defining I2C_RX_GLITCH_FILTER_EN.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [6:0] own_addr,
  input  logic       rx_ready,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       start_det,
  output logic       stop_det,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned        CNT_W     = 3;
  localparam logic [CNT_W-1:0]   ADDR_LAST = CNT_W'(I2C_BYTE_BITS - 2);
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(I2C_BYTE_BITS - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .ref_clk (ref_clk),
    .reset   (reset),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise_c  (scl_rise),
    .fall_c  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .ref_clk (ref_clk),
    .reset   (reset),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise_c  (sda_rise),
    .fall_c  (sda_fall)
  );

  i2c_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic             addr_hit_q, addr_hit_d;
  logic             ack_bit_q, ack_bit_d;
  logic             ack_phase_q, ack_phase_d;
  logic             sda_oe_q, sda_oe_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             addr_match_q, addr_match_d;
  logic             start_det_q, start_det_d;
  logic             stop_det_q, stop_det_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  logic       start_c, stop_c;
  logic [7:0] byte_c;

  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;
  assign byte_c  = {shift_q, sda_lvl};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_hit_d   = addr_hit_q;
    ack_bit_d    = ack_bit_q;
    ack_phase_d  = ack_phase_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    addr_match_d = 1'b0;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    overflow_d   = overflow_q;
    busy_d       = busy_q;

    // sda_oe only ever moves after a filtered SCL fall; the ACK states override below.
    if (scl_fall) sda_oe_d = 1'b0;

    if (stop_c) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
      busy_d     = 1'b0;
    end else if (start_c) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      start_det_d = 1'b1;
      busy_d      = 1'b1;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_c[6:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == ADDR_LAST) addr_hit_d = (byte_c[6:0] == own_addr);
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d   = '0;
              ack_phase_d = 1'b0;
              if (addr_hit_q && (sda_lvl == I2C_RW_WRITE)) begin
                state_d      = ADDR_ACK;
                addr_match_d = 1'b1;
                ack_bit_d    = I2C_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_oe_d    = (ack_bit_q == I2C_ACK);
            end else begin
              ack_phase_d = 1'b0;
              sda_oe_d    = 1'b0;
              bit_cnt_d   = '0;
              state_d     = (ack_bit_q == I2C_ACK) ? DATA : IGNORE;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d   = byte_c[6:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d   = '0;
              rx_data_d   = byte_c;
              rx_valid_d  = rx_ready;
              ack_bit_d   = rx_ready ? I2C_ACK : ~I2C_ACK;
              ack_phase_d = 1'b0;
              state_d     = DATA_ACK;
              if (!rx_ready) overflow_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_hit_q   <= 1'b0;
      ack_bit_q    <= ~I2C_ACK;
      ack_phase_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_hit_q   <= addr_hit_d;
      ack_bit_q    <= ack_bit_d;
      ack_phase_q  <= ack_phase_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: table of write transfers plus repeated-START, glitch and reset sequences.
module tb_i2c_target_rx;

  localparam int Q = 10;

`ifdef I2C_RX_GLITCH_FILTER_EN
  localparam int GLITCH_EDGES = 0;
`else
  localparam int GLITCH_EDGES = 1;
`endif

  logic       ref_clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_in;
  logic [6:0] own_addr;
  logic       rx_ready;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       start_det;
  logic       stop_det;
  logic       overflow;
  logic       busy;

  assign sda_in = sda_m & ~sda_oe;

  i2c_target_rx #(.FILTER_LEN(3)) dut (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .scl_in     (scl_m),
    .sda_in     (sda_in),
    .own_addr   (own_addr),
    .rx_ready   (rx_ready),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .addr_match (addr_match),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 ref_clk = ~ref_clk;

  // Bus monitor: pulse counters, pulse width and sda_oe-while-SCL-high violations.
  int         start_cnt = 0, stop_cnt = 0, am_cnt = 0, rv_cnt = 0;
  int         pulse_long = 0, oe_viol = 0;
  logic [7:0] last_data = 8'h00;
  logic       start_p = 1'b0, stop_p = 1'b0, am_p = 1'b0, rv_p = 1'b0, oe_p = 1'b0;

  always @(negedge ref_clk) begin
    if (start_det)  start_cnt <= start_cnt + 1;
    if (stop_det)   stop_cnt  <= stop_cnt + 1;
    if (addr_match) am_cnt    <= am_cnt + 1;
    if (rx_valid) begin
      rv_cnt    <= rv_cnt + 1;
      last_data <= rx_data;
    end
    if ((start_det && start_p) || (stop_det && stop_p) ||
        (addr_match && am_p) || (rx_valid && rv_p))
      pulse_long <= pulse_long + 1;
    if ((sda_oe != oe_p) && scl_m) oe_viol <= oe_viol + 1;
    start_p <= start_det;
    stop_p  <= stop_det;
    am_p    <= addr_match;
    rv_p    <= rx_valid;
    oe_p    <= sda_oe;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    cyc(2 * Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    ack = ~sda_in;
    cyc(Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic start_seq();
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic stop_seq();
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b1;
    cyc(2 * Q);
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] data_b;
    logic       rdy;
    logic       exp_am;
    logic       exp_aack;
    logic       exp_dack;
    logic       exp_rv;
    logic [7:0] exp_rxd;
    logic       exp_ovf;
  } vec_t;

  vec_t       vecs [6];
  int         s0, p0, a0, r0;
  logic       aack, dack, ack3;
  logic [7:0] abyte;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{8'hA2, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[2] = '{8'hA1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[3] = '{8'hA0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1};
    vecs[4] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};

    reset    = 1'b0;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rx_ready = 1'b1;
    own_addr = 7'h50;
    cyc(5);
    check("rst_sda_oe",     32'(sda_oe),     32'(0));
    check("rst_rx_data",    32'(rx_data),    32'(0));
    check("rst_rx_valid",   32'(rx_valid),   32'(0));
    check("rst_addr_match", 32'(addr_match), 32'(0));
    check("rst_start_det",  32'(start_det),  32'(0));
    check("rst_stop_det",   32'(stop_det),   32'(0));
    check("rst_overflow",   32'(overflow),   32'(0));
    check("rst_busy",       32'(busy),       32'(0));
    reset = 1'b1;
    cyc(20);
    check("post_rst_no_start", 32'(start_cnt), 32'(0));
    check("post_rst_busy",     32'(busy),      32'(0));

    for (int k = 0; k < 6; k++) begin
      rx_ready = vecs[k].rdy;
      s0 = start_cnt; p0 = stop_cnt; a0 = am_cnt; r0 = rv_cnt;
      start_seq();
      send_byte(vecs[k].addr_b, aack);
      check($sformatf("v%0d_busy_mid", k), 32'(busy), 32'(1));
      send_byte(vecs[k].data_b, dack);
      stop_seq();
      check($sformatf("v%0d_start", k), 32'(start_cnt - s0), 32'(1));
      check($sformatf("v%0d_stop", k),  32'(stop_cnt - p0),  32'(1));
      check($sformatf("v%0d_am", k),    32'(am_cnt - a0),    32'(vecs[k].exp_am));
      check($sformatf("v%0d_aack", k),  32'(aack),           32'(vecs[k].exp_aack));
      check($sformatf("v%0d_dack", k),  32'(dack),           32'(vecs[k].exp_dack));
      check($sformatf("v%0d_rv", k),    32'(rv_cnt - r0),    32'(vecs[k].exp_rv));
      if (vecs[k].exp_rv)
        check($sformatf("v%0d_rv_data", k), 32'(last_data), 32'(vecs[k].data_b));
      check($sformatf("v%0d_rx_data", k), 32'(rx_data),  32'(vecs[k].exp_rxd));
      check($sformatf("v%0d_overflow", k), 32'(overflow), 32'(vecs[k].exp_ovf));
      check($sformatf("v%0d_busy_end", k), 32'(busy),     32'(0));
    end
    rx_ready = 1'b1;

    // Repeated START after 4 data bits; only the byte of the second transfer is delivered.
    s0 = start_cnt; a0 = am_cnt; r0 = rv_cnt;
    start_seq();
    send_byte(8'hA0, aack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    start_seq();
    send_byte(8'hA0, aack);
    send_byte(8'h55, ack3);
    stop_seq();
    check("rs_start",   32'(start_cnt - s0), 32'(2));
    check("rs_am",      32'(am_cnt - a0),    32'(2));
    check("rs_rv",      32'(rv_cnt - r0),    32'(1));
    check("rs_rv_data", 32'(last_data),      32'(8'h55));
    check("rs_ack",     32'(ack3),           32'(1));

    // SDA glitches on an idle bus with SCL high.
    s0 = start_cnt; p0 = stop_cnt;
    sda_m = 1'b0;
    cyc(1);
    sda_m = 1'b1;
    cyc(20);
    check("glitch1_start", 32'(start_cnt - s0), 32'(GLITCH_EDGES));
    check("glitch1_stop",  32'(stop_cnt - p0),  32'(GLITCH_EDGES));
    s0 = start_cnt; p0 = stop_cnt;
    sda_m = 1'b0;
    cyc(3);
    sda_m = 1'b1;
    cyc(20);
    check("glitch3_start", 32'(start_cnt - s0), 32'(1));
    check("glitch3_stop",  32'(stop_cnt - p0),  32'(1));
    check("glitch3_busy",  32'(busy),           32'(0));

    // Reset while the target is driving the address ACK.
    a0 = am_cnt; r0 = rv_cnt;
    start_seq();
    abyte = 8'hA0;
    for (int i = 7; i >= 0; i--) send_bit(abyte[i]);
    check("mid_oe_before_reset", 32'(sda_oe), 32'(1));
    reset = 1'b0;
    cyc(1);
    check("mid_reset_outputs",
          32'({sda_oe, rx_data, rx_valid, addr_match, start_det, stop_det, overflow, busy}),
          32'(0));
    reset = 1'b1;
    send_bit(1'b1);
    abyte = 8'h3C;
    for (int i = 7; i >= 0; i--) send_bit(abyte[i]);
    check("mid_reset_busy", 32'(busy),         32'(0));
    check("mid_reset_am",   32'(am_cnt - a0),  32'(1));
    check("mid_reset_rv",   32'(rv_cnt - r0),  32'(0));
    stop_seq();

    // Rejoin on the next START.
    r0 = rv_cnt;
    start_seq();
    send_byte(8'hA0, aack);
    send_byte(8'h96, dack);
    stop_seq();
    check("rejoin_rv",      32'(rv_cnt - r0), 32'(1));
    check("rejoin_rv_data", 32'(last_data),   32'(8'h96));

    check("oe_stable_scl_high", 32'(oe_viol),    32'(0));
    check("pulse_width",        32'(pulse_long), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
